rf_black_widow_insn_queue: RTL and testbench
============================================

RF_BLACK_WIDOW_INSN_QUEUE -- requirements
Module: rf_black_widow_insn_queue

Interface
REQ-001 Parameter: QDEP, 8, queue depth in instructions; power of two, >=8.
REQ-002 Port: clk_i  input  1  sole clock, all state rising-edge.
REQ-003 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port: flush_i  input  1  discard all queued instructions (branch redirect).
REQ-005 Port: fetch_valid_i  input  1  fetch lanes valid this cycle.
REQ-006 Port: fetch_cnt_i  input  2  number of valid lanes, 1 or 2; 0/3 treated as no push.
REQ-007 Port: fetch_insn_i  input  2 x Instruction  lane 0 older than lane 1.
REQ-008 Port: fetch_ready_o  output  1  at least 2 free entries.
REQ-009 Port: ir_o, ir1_o, ir2_o, ir3_o  output  Instruction each  head window, oldest first, to decoder.
REQ-010 Port: bundle_len_o  output  3  words in head bundle, 1..4.
REQ-011 Port: dec_valid_o  output  1  complete bundle present at head.
REQ-012 Port: dec_ready_i  input  1  decoder accepts head bundle.
REQ-013 Port: count_o  output  $clog2(QDEP)+1  occupied entries.

Function
REQ-014 Storage: circular array of QDEP Instruction; rd/wr pointers carry an extra wrap bit; full when pointers equal except wrap bit.
REQ-015 Push occurs when fetch_valid_i & fetch_ready_o & !flush_i; writes fetch_cnt_i lanes at wr_ptr, wr_ptr+1 modulo QDEP.
REQ-016 Pushed words visible on the window outputs the cycle after the push; no same-cycle bypass.
REQ-017 Window: irN_o = entry rd_ptr+N modulo QDEP when N < count_o, else NOP_INSN.
REQ-018 bundle_len_o = 1 + number of consecutive CON1/CON2/CON3 opcodes in ir1_o..ir3_o, stopping at first non-CON or empty slot; max 4.
REQ-019 Bundle complete when: len==4; or count_o > len; or count_o == len and no push this cycle (fetch drained).
REQ-020 dec_valid_o = count_o>=1 & bundle complete & !flush_i.
REQ-021 Pop occurs when dec_valid_o & dec_ready_i; rd_ptr advances by bundle_len_o.
REQ-022 Simultaneous push and pop: count_o next = count_o + pushed - popped; both pointers update the same edge.
REQ-023 fetch_ready_o = (QDEP - count_o) >= 2, from registered count (no pop look-ahead).
REQ-024 flush_i: next cycle rd_ptr = wr_ptr = 0, count_o = 0; push and pop that cycle suppressed.
REQ-025 Orphan CON at head (head opcode is CON1/2/3): presented as a length-1 bundle; decoder treats it as NOP.
REQ-026 Pointer wrap past QDEP-1 transparent to window and bundle logic.

Reset
REQ-027 rst_ni low asynchronously clears rd_ptr, wr_ptr, count_o to 0.
REQ-028 During and after reset until first push: dec_valid_o 0, fetch_ready_o 1, irN_o NOP_INSN, bundle_len_o 1.
REQ-029 Array contents not reset; never observable because REQ-017 masks empty slots.
REQ-030 Reset deasserting mid-operation resumes as empty queue; no stale bundle is presented.

Structure
REQ-031 NOP_INSN constant and function isCon(opcode) belong in rfBlackWidowPkg; Instruction type and CON1..CON3 already reside there.
REQ-032 Bundle length/completeness logic in one combinational sub-module rf_black_widow_bundle_len (inputs: window, count, push; outputs: len, complete).
REQ-033 Decoder instance connects ir_o..ir3_o directly to its ir..ir3 inputs.

Verification
REQ-034 Reset, then push 2 ADDI; next cycle dec_valid_o 1, bundle_len_o 1, ir_o first ADDI, count_o 2; pop -> count_o 1.
REQ-035 Push LDD, CON1, CON2, ADDI over two cycles -> bundle_len_o 3, dec_valid_o 1; pop -> ir_o = ADDI, count_o 1.
REQ-036 Push LDD then stall fetch with CON1 in flight: cycle with count 1 and push of CON1 -> dec_valid_o 0; after push bundle_len_o 2.
REQ-037 Fill QDEP=8 to 7 entries -> fetch_ready_o 0; pop 1-word bundle -> fetch_ready_o 1 next cycle; push across index 7->0 reads back in order.
REQ-038 flush_i asserted with push and pop requested -> neither occurs; next cycle count_o 0, dec_valid_o 0, ir_o NOP_INSN.
REQ-039 Assert rst_ni low asynchronously between edges with 5 entries queued -> count_o 0 immediately; dec_valid_o 0 until new push.

Source files
------------

// File: rtl/rfBlackWidowPkg.sv
// Shared instruction encoding and helpers for the Black Widow front end.
package rfBlackWidowPkg;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_ADDI = 6'd1,
        OP_LDD  = 6'd2,
        OP_ST   = 6'd3,
        OP_BR   = 6'd4,
        OP_CON1 = 6'd60,
        OP_CON2 = 6'd61,
        OP_CON3 = 6'd62
    } opcode_e;

    typedef struct packed {
        opcode_e     opcode;
        logic [25:0] operand;
    } Instruction;

    localparam Instruction NOP_INSN = '{opcode: OP_NOP, operand: 26'd0};

    // CON words extend the operand field of the instruction in front of them.
    function automatic logic isCon(input opcode_e op);
        return (op == OP_CON1) || (op == OP_CON2) || (op == OP_CON3);
    endfunction

endpackage

// File: rtl/rf_black_widow_insn_queue_if.sv
// Fetch-side push lanes and decoder-side head window of the instruction queue.
interface rf_black_widow_insn_queue_if
    import rfBlackWidowPkg::*;
#(
    parameter int QDEP = 8
) ();
    localparam int CNT_W = $clog2(QDEP) + 1;

    logic                   fetch_valid_i;
    logic [1:0]             fetch_cnt_i;
    Instruction [1:0]       fetch_insn_i;
    logic                   fetch_ready_o;
    Instruction             ir_o;
    Instruction             ir1_o;
    Instruction             ir2_o;
    Instruction             ir3_o;
    logic [2:0]             bundle_len_o;
    logic                   dec_valid_o;
    logic                   dec_ready_i;
    logic [CNT_W-1:0]       count_o;

    modport slave (
        input  fetch_valid_i, fetch_cnt_i, fetch_insn_i, dec_ready_i,
        output fetch_ready_o, ir_o, ir1_o, ir2_o, ir3_o, bundle_len_o, dec_valid_o, count_o
    );

    modport master (
        output fetch_valid_i, fetch_cnt_i, fetch_insn_i, dec_ready_i,
        input  fetch_ready_o, ir_o, ir1_o, ir2_o, ir3_o, bundle_len_o, dec_valid_o, count_o
    );

endinterface

// File: rtl/rf_black_widow_bundle_len.sv
// Combinational bundle length (head word plus trailing CON words, max 4) and completeness.
// A bundle that may still grow from the word being pushed this cycle is held back.
module rf_black_widow_bundle_len
    import rfBlackWidowPkg::*;
#(
    parameter int CNT_W = 4
) (
    input  Instruction       win_i [4],
    input  logic [CNT_W-1:0] count_i,
    input  logic             push_i,
    output logic [2:0]       len_o,
    output logic             complete_o
);

    logic orphan;
    logic run;

    always_comb begin
        orphan = isCon(win_i[0].opcode);
        run    = !orphan;
        len_o  = 3'd1;
        // Empty slots read as NOP, so the CON run stops at the queue tail.
        for (int n = 1; n < 4; n++) begin
            run = run & isCon(win_i[n].opcode);
            if (run) begin
                len_o = len_o + 3'd1;
            end
        end
        complete_o = (len_o == 3'd4)
                   || (count_i > CNT_W'(len_o))
                   || ((count_i == CNT_W'(len_o)) && !push_i)
                   || (orphan && (count_i != '0));
    end

endmodule

// File: rtl/rf_black_widow_insn_queue.sv
// Circular instruction queue: 2-lane push from fetch, variable-length bundle pop to decode.
// Pushed words appear on the window one cycle later; fetch_ready_o drops below two free slots.
module rf_black_widow_insn_queue
    import rfBlackWidowPkg::*;
#(
    parameter int QDEP = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    rf_black_widow_insn_queue_if.slave    q_if
);

    localparam int PTR_W = $clog2(QDEP);
    localparam int PW    = PTR_W + 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    Instruction       mem_q [QDEP];

    Instruction       win [4];
    logic [PTR_W-1:0] rd_idx;
    logic [PTR_W-1:0] wr_idx0, wr_idx1;
    logic [1:0]       push_cnt;
    logic [2:0]       len;
    logic             complete;
    logic             fetch_ready;
    logic             dec_valid;
    logic             push;
    logic             pop;

    assign fetch_ready = (count_q <= CNT_W'(QDEP - 2));

    always_comb begin
        push_cnt = 2'd0;
        if (q_if.fetch_cnt_i == 2'd1 || q_if.fetch_cnt_i == 2'd2) begin
            push_cnt = q_if.fetch_cnt_i;
        end
    end

    assign push = q_if.fetch_valid_i & fetch_ready & !flush_i & (push_cnt != 2'd0);

    // Slots at or beyond the occupancy are masked so stale array contents never leak out.
    always_comb begin
        rd_idx = '0;
        for (int n = 0; n < 4; n++) begin
            rd_idx = rd_ptr_q[PTR_W-1:0] + PTR_W'(n);
            win[n] = NOP_INSN;
            if (CNT_W'(n) < count_q) begin
                win[n] = mem_q[rd_idx];
            end
        end
    end

    rf_black_widow_bundle_len #(
        .CNT_W (CNT_W)
    ) u_bundle_len (
        .win_i      (win),
        .count_i    (count_q),
        .push_i     (push),
        .len_o      (len),
        .complete_o (complete)
    );

    assign dec_valid = (count_q != '0) & complete & !flush_i;
    assign pop       = dec_valid & q_if.dec_ready_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(len);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(push_cnt);
            end
            count_d = count_q + (push ? CNT_W'(push_cnt) : '0) - (pop ? CNT_W'(len) : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_idx0 = wr_ptr_q[PTR_W-1:0];
    assign wr_idx1 = wr_idx0 + PTR_W'(1);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_idx0] <= q_if.fetch_insn_i[0];
            if (push_cnt == 2'd2) begin
                mem_q[wr_idx1] <= q_if.fetch_insn_i[1];
            end
        end
    end

    assign q_if.fetch_ready_o = fetch_ready;
    assign q_if.ir_o          = win[0];
    assign q_if.ir1_o         = win[1];
    assign q_if.ir2_o         = win[2];
    assign q_if.ir3_o         = win[3];
    assign q_if.bundle_len_o  = len;
    assign q_if.dec_valid_o   = dec_valid;
    assign q_if.count_o       = count_q;

endmodule

// File: tb/tb_rf_black_widow_insn_queue.sv
// Directed-vector bench for the Black Widow instruction queue (QDEP = 8).
module tb_rf_black_widow_insn_queue;
    import rfBlackWidowPkg::*;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic flush_i = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk_i = ~clk_i;

    rf_black_widow_insn_queue_if #(.QDEP(8)) q_if ();

    rf_black_widow_insn_queue #(.QDEP(8)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .q_if    (q_if.slave)
    );

    localparam Instruction N  = NOP_INSN;
    localparam Instruction A1 = '{opcode: OP_ADDI, operand: 26'd1};
    localparam Instruction A2 = '{opcode: OP_ADDI, operand: 26'd2};
    localparam Instruction A3 = '{opcode: OP_ADDI, operand: 26'd3};
    localparam Instruction A4 = '{opcode: OP_ADDI, operand: 26'd4};
    localparam Instruction A5 = '{opcode: OP_ADDI, operand: 26'd5};
    localparam Instruction A6 = '{opcode: OP_ADDI, operand: 26'd6};
    localparam Instruction A7 = '{opcode: OP_ADDI, operand: 26'd7};
    localparam Instruction B1 = '{opcode: OP_ST,   operand: 26'd11};
    localparam Instruction B2 = '{opcode: OP_ST,   operand: 26'd12};
    localparam Instruction L  = '{opcode: OP_LDD,  operand: 26'd20};
    localparam Instruction C1 = '{opcode: OP_CON1, operand: 26'd31};
    localparam Instruction C2 = '{opcode: OP_CON2, operand: 26'd32};
    localparam Instruction C3 = '{opcode: OP_CON3, operand: 26'd33};

    typedef struct {
        logic       fl;
        logic       fv;
        logic [1:0] fc;
        Instruction i0;
        Instruction i1;
        logic       dr;
        logic       e_dv;
        logic [2:0] e_len;
        Instruction e_ir0;
        Instruction e_ir1;
        logic [3:0] e_cnt;
        logic       e_fr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fl, logic fv, logic [1:0] fc, Instruction i0, Instruction i1,
                                logic dr, logic dv, logic [2:0] ln, Instruction e0, Instruction e1,
                                logic [3:0] cnt, logic fr);
        vec_t v;
        v.fl = fl; v.fv = fv; v.fc = fc; v.i0 = i0; v.i1 = i1; v.dr = dr;
        v.e_dv = dv; v.e_len = ln; v.e_ir0 = e0; v.e_ir1 = e1; v.e_cnt = cnt; v.e_fr = fr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [1:0] fc,
                         input Instruction i0, input Instruction i1, input logic dr);
        flush_i              = fl;
        q_if.fetch_valid_i   = fv;
        q_if.fetch_cnt_i     = fc;
        q_if.fetch_insn_i[0] = i0;
        q_if.fetch_insn_i[1] = i1;
        q_if.dec_ready_i     = dr;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " count"},     32'(q_if.count_o), 32'd0);
        chk({tag, " dec_valid"}, 32'(q_if.dec_valid_o), 32'd0);
        chk({tag, " ir"},        32'(q_if.ir_o), 32'(N));
        chk({tag, " fetch_rdy"}, 32'(q_if.fetch_ready_o), 32'd1);
        chk({tag, " len"},       32'(q_if.bundle_len_o), 32'd1);
    endtask

    initial begin
        // fl fv fc i0 i1 dr | dv len ir0 ir1 cnt fr
        vecs.push_back(mk(0,0,0,N ,N ,0, 0,1,N ,N ,0,1));
        vecs.push_back(mk(0,1,3,A1,A2,0, 0,1,N ,N ,0,1));
        vecs.push_back(mk(0,1,2,A1,A2,0, 0,1,N ,N ,0,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,A1,A2,2,1));
        vecs.push_back(mk(0,0,0,N ,N ,0, 1,1,A2,N ,1,1));
        vecs.push_back(mk(1,1,2,B1,B2,1, 0,1,A2,N ,1,1));
        vecs.push_back(mk(0,1,2,L ,C1,0, 0,1,N ,N ,0,1));
        vecs.push_back(mk(0,1,2,C2,A3,0, 0,2,L ,C1,2,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,3,L ,C1,4,1));
        vecs.push_back(mk(0,0,0,N ,N ,0, 1,1,A3,N ,1,1));
        vecs.push_back(mk(1,0,0,N ,N ,0, 0,1,A3,N ,1,1));
        vecs.push_back(mk(0,1,1,L ,N ,0, 0,1,N ,N ,0,1));
        vecs.push_back(mk(0,1,1,C1,N ,1, 0,1,L ,N ,1,1));
        vecs.push_back(mk(0,0,0,N ,N ,0, 1,2,L ,C1,2,1));
        vecs.push_back(mk(1,0,0,N ,N ,0, 0,2,L ,C1,2,1));
        vecs.push_back(mk(0,1,2,A1,A2,0, 0,1,N ,N ,0,1));
        vecs.push_back(mk(0,1,2,A3,A4,0, 1,1,A1,A2,2,1));
        vecs.push_back(mk(0,1,2,A5,A6,0, 1,1,A1,A2,4,1));
        vecs.push_back(mk(0,1,1,A7,N ,0, 1,1,A1,A2,6,1));
        vecs.push_back(mk(0,1,2,B1,B2,0, 1,1,A1,A2,7,0));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,A1,A2,7,0));
        vecs.push_back(mk(0,1,2,B1,B2,0, 1,1,A2,A3,6,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,A2,A3,8,0));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,A3,A4,7,0));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,A4,A5,6,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,A5,A6,5,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,A6,A7,4,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,A7,B1,3,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,B1,B2,2,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,B2,N ,1,1));
        vecs.push_back(mk(0,0,0,N ,N ,0, 0,1,N ,N ,0,1));
        vecs.push_back(mk(0,1,2,L ,C1,0, 0,1,N ,N ,0,1));
        vecs.push_back(mk(0,1,2,C2,C3,0, 0,2,L ,C1,2,1));
        vecs.push_back(mk(0,1,2,C1,A1,1, 1,4,L ,C1,4,1));
        vecs.push_back(mk(0,0,0,N ,N ,1, 1,1,C1,A1,2,1));
        vecs.push_back(mk(0,0,0,N ,N ,0, 1,1,A1,N ,1,1));

        drive(0, 0, 2'd0, N, N, 0);
        #1;
        chk_idle("in_reset");
        @(negedge clk_i);
        chk_idle("reset_held");
        rst_ni = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            if (k != 0) @(negedge clk_i);
            drive(vecs[k].fl, vecs[k].fv, vecs[k].fc, vecs[k].i0, vecs[k].i1, vecs[k].dr);
            #2;
            chk($sformatf("v%0d dec_valid", k), 32'(q_if.dec_valid_o),   32'(vecs[k].e_dv));
            chk($sformatf("v%0d len", k),       32'(q_if.bundle_len_o),  32'(vecs[k].e_len));
            chk($sformatf("v%0d ir", k),        32'(q_if.ir_o),          32'(vecs[k].e_ir0));
            chk($sformatf("v%0d ir1", k),       32'(q_if.ir1_o),         32'(vecs[k].e_ir1));
            chk($sformatf("v%0d count", k),     32'(q_if.count_o),       32'(vecs[k].e_cnt));
            chk($sformatf("v%0d fetch_rdy", k), 32'(q_if.fetch_ready_o), 32'(vecs[k].e_fr));
        end

        // Build up five entries, then pull reset between edges.
        @(negedge clk_i);
        drive(0, 1, 2'd2, B1, B2, 0);
        @(negedge clk_i);
        drive(0, 1, 2'd2, A3, A4, 0);
        @(negedge clk_i);
        drive(0, 0, 2'd0, N, N, 0);
        #2;
        chk("pre_rst count", 32'(q_if.count_o), 32'd5);
        chk("pre_rst ir", 32'(q_if.ir_o), 32'(A1));
        #1;
        rst_ni = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            #2;
            chk_idle("post_rst");
        end
        @(negedge clk_i);
        drive(0, 1, 2'd1, A5, N, 0);
        #2;
        chk("post_rst push dec_valid", 32'(q_if.dec_valid_o), 32'd0);
        @(negedge clk_i);
        drive(0, 0, 2'd0, N, N, 0);
        #2;
        chk("post_rst new dec_valid", 32'(q_if.dec_valid_o), 32'd1);
        chk("post_rst new ir", 32'(q_if.ir_o), 32'(A5));
        chk("post_rst new ir1", 32'(q_if.ir1_o), 32'(N));
        chk("post_rst new count", 32'(q_if.count_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
